// File: rtl/silife_sched_pkg.sv
// Shared types and default sizing for the silife generation scheduler.
package silife_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_HOST = 2'd2
  } sched_state_e;

  localparam int unsigned PERIOD_W_DEF    = 16;
  localparam int unsigned GEN_W_DEF       = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/silife_period_timer.sv
// Loadable down counter that paces generations; a load of zero is stored as one.
module silife_period_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic                le1_o
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] load_val;

  assign load_val = (load_val_i == '0) ? ONE : load_val_i;
  assign le1_o    = (cnt_q[PERIOD_W-1:1] == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val;
    end else if (dec_i && !le1_o) begin
      cnt_q <= cnt_q - ONE;
    end
  end

endmodule

// File: rtl/silife_gen_scheduler.sv
// Generation scheduler: paces grid steps, arbitrates grid ownership with the host
// loader, counts completed generations and flags engine timeouts.
module silife_gen_scheduler
  import silife_sched_pkg::*;
#(
  parameter int unsigned PERIOD_W    = PERIOD_W_DEF,
  parameter int unsigned GEN_W       = GEN_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                single_step,
  input  logic [PERIOD_W-1:0] period,
  input  logic                host_req,
  output logic                host_gnt,
  output logic                step_start,
  input  logic                step_done,
  output logic                busy,
  output logic [GEN_W-1:0]    gen_count,
  output logic                err_timeout
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  sched_state_e     state_q, state_d;
  logic             ss_pend_q, ss_pend_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             err_q, err_d;
  logic             host_gnt_q, host_gnt_d;
  logic             step_start_q, step_start_d;
  logic             busy_q, busy_d;

  logic tmr_load, tmr_dec, tmr_le1;
  logic fire, fire_now;

  silife_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (period),
    .dec_i      (tmr_dec),
    .le1_o      (tmr_le1)
  );

  // Free-run fires on pacing expiry; paused only a pending single-step fires.
  assign fire     = enable ? tmr_le1 : ss_pend_q;
  assign fire_now = (state_q == ST_IDLE) && !host_req && fire;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    gen_d    = gen_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host_req) begin
          state_d = ST_HOST;
        end else if (fire) begin
          state_d = ST_STEP;
          tmo_d   = '0;
        end else if (enable) begin
          tmr_dec = 1'b1;
        end
      end
      ST_STEP: begin
        if (step_done) begin
          gen_d    = gen_q + GEN_W'(1);
          tmr_load = 1'b1;
          state_d  = host_req ? ST_HOST : ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_HOST: begin
        if (!host_req) begin
          tmr_load = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ss_pend_d    = enable ? 1'b0 : ((ss_pend_q && !fire_now) || single_step);
    host_gnt_d   = (state_d == ST_HOST);
    busy_d       = (state_d == ST_STEP);
    step_start_d = (state_q == ST_IDLE) && (state_d == ST_STEP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ss_pend_q    <= 1'b0;
      tmo_q        <= '0;
      gen_q        <= '0;
      err_q        <= 1'b0;
      host_gnt_q   <= 1'b0;
      step_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ss_pend_q    <= ss_pend_d;
      tmo_q        <= tmo_d;
      gen_q        <= gen_d;
      err_q        <= err_d;
      host_gnt_q   <= host_gnt_d;
      step_start_q <= step_start_d;
      busy_q       <= busy_d;
    end
  end

  assign host_gnt    = host_gnt_q;
  assign step_start  = step_start_q;
  assign busy        = busy_q;
  assign gen_count   = gen_q;
  assign err_timeout = err_q;

endmodule
